scp_rom_server: RTL

SCP_ROM_SERVER -- requirements
Module: scp_rom_server

---
 rtl/scp_rom_server_if.sv | 37 +++
 rtl/scp_rom_server.sv | 119 +++++++++++
 2 files changed

// File: rtl/scp_rom_server_if.sv
// Bus bundle between the tilemap fetcher, the ROM server and the SDRAM burst port.
// The slave modport is the server's view; master is the fetcher/SDRAM side.
interface scp_rom_server_if;
  logic [20:0] rom_address;
  logic        rom_req;
  logic        rom_ack;
  logic [63:0] rom_data;
  logic        flush;
  logic [25:0] sdr_addr;
  logic        sdr_rd;
  logic [15:0] sdr_data;
  logic        sdr_valid;

  modport master (
    output rom_address,
    output rom_req,
    output flush,
    output sdr_data,
    output sdr_valid,
    input  rom_ack,
    input  rom_data,
    input  sdr_addr,
    input  sdr_rd
  );

  modport slave (
    input  rom_address,
    input  rom_req,
    input  flush,
    input  sdr_data,
    input  sdr_valid,
    output rom_ack,
    output rom_data,
    output sdr_addr,
    output sdr_rd
  );
endinterface

// File: rtl/scp_rom_server.sv
// Tile ROM server: toggle-handshake quadword reads backed by a one-entry hit
// register, refilled by 4-beat 16-bit SDRAM bursts.
module scp_rom_server #(
  parameter logic [25:0] ROM_BASE = 26'h000000
) (
  input  logic             clk,
  input  logic             reset,
  scp_rom_server_if.slave  bus
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  beat_cnt;
  logic [17:0] fetch_tag;
  logic [17:0] hit_tag;
  logic [63:0] hit_data;
  logic        hit_valid;
  logic [47:0] asm_data;

  logic        pending;
  logic        tag_match;
  logic        take_hit;
  logic        take_miss;
  logic        take_beat;
  logic        take_last;

  // Byte address of the burst; the sum is truncated to 26 bits so it wraps.
  function automatic logic [25:0] burst_addr(input logic [17:0] qw);
    return ROM_BASE + {5'd0, qw, 3'd0};
  endfunction

  assign pending   = (bus.rom_req != bus.rom_ack);
  assign tag_match = hit_valid && (hit_tag == bus.rom_address[20:3]) && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    take_beat  = 1'b0;
    take_last  = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          if (tag_match) begin
            take_hit = 1'b1;
          end else begin
            take_miss  = 1'b1;
            state_next = FETCH;
          end
        end
      end
      FETCH: begin
        if (bus.sdr_valid) begin
          take_beat = 1'b1;
          if (beat_cnt == 2'd3) begin
            take_last  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake, burst request and hit-valid control
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rom_ack  <= 1'b0;
      bus.rom_data <= 64'd0;
      bus.sdr_rd   <= 1'b0;
      bus.sdr_addr <= 26'd0;
      hit_valid    <= 1'b0;
      beat_cnt     <= 2'd0;
    end else begin
      bus.sdr_rd <= take_miss;
      if (take_hit) begin
        bus.rom_data <= hit_data;
        bus.rom_ack  <= ~bus.rom_ack;
      end
      if (take_miss) begin
        bus.sdr_addr <= burst_addr(bus.rom_address[20:3]);
        beat_cnt     <= 2'd0;
      end
      if (take_beat) beat_cnt <= beat_cnt + 2'd1;
      if (take_last) begin
        bus.rom_data <= {bus.sdr_data, asm_data};
        bus.rom_ack  <= ~bus.rom_ack;
      end
      // A flush on the fill edge still delivers data but leaves the entry invalid.
      if (take_last)     hit_valid <= !bus.flush;
      else if (bus.flush) hit_valid <= 1'b0;
    end
  end

  // Burst assembly and hit-register contents
  always_ff @(posedge clk) begin
    if (take_miss) fetch_tag <= bus.rom_address[20:3];
    if (take_beat && !take_last) begin
      case (beat_cnt)
        2'd0:    asm_data[15:0]  <= bus.sdr_data;
        2'd1:    asm_data[31:16] <= bus.sdr_data;
        2'd2:    asm_data[47:32] <= bus.sdr_data;
        default: ;
      endcase
    end
    if (take_last) begin
      hit_tag  <= fetch_tag;
      hit_data <= {bus.sdr_data, asm_data};
    end
  end

endmodule
